mem_responder: RTL and testbench

Memory-side responder for the datapath controller's memory port. It accepts the controller's request (w1 = write, addr1 = address, data1 = write data) and services it against a synchronous block RAM or a small memory-mapped I/O window. It returns read data on the 18-bit external_din bus with a single-cycle ready pulse. Its FSM handles RAM read latency, I/O decode and out-of-range errors.

---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: services controller requests against a synchronous block RAM
// or a small memory-mapped I/O window, returning read data with a one-cycle ready pulse.
module mem_responder #(
  parameter int          RAM_LATENCY = 1,
  parameter logic [15:0] IO_BASE     = 16'hFF00,
  parameter logic [15:0] IO_OUT_ADDR = 16'hFF00,
  parameter logic [15:0] IO_IN_ADDR  = 16'hFF01
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req,
  input  logic        w1,
  input  logic [15:0] addr1,
  input  logic [15:0] data1,
  output logic [17:0] external_din,
  output logic        ready,
  output logic        err,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [17:0] ram_rdata,
  output logic [15:0] io_out,
  input  logic [15:0] io_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Counter value on the edge where the RAM read data is valid.
  localparam logic [2:0] LAST_CNT = 3'(RAM_LATENCY - 1);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [17:0] din_r, din_s;
  logic        ready_r, ready_s;
  logic        err_r, err_s;
  logic [14:0] ram_addr_r, ram_addr_s;
  logic        ram_we_r, ram_we_s;
  logic [15:0] ram_wdata_r, ram_wdata_s;
  logic [15:0] io_out_r, io_out_s;

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      din_r       <= 18'd0;
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      ram_addr_r  <= 15'd0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= 16'd0;
      io_out_r    <= 16'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      din_r       <= din_s;
      ready_r     <= ready_s;
      err_r       <= err_s;
      ram_addr_r  <= ram_addr_s;
      ram_we_r    <= ram_we_s;
      ram_wdata_r <= ram_wdata_s;
      io_out_r    <= io_out_s;
    end
  end

  // Next-state and next-output decode; pulses default low so they last one cycle.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    din_s       = din_r;
    ready_s     = 1'b0;
    err_s       = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_we_s    = 1'b0;
    ram_wdata_s = ram_wdata_r;
    io_out_s    = io_out_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (!addr1[15]) begin
            ram_addr_s = addr1[14:0];
            if (w1) begin
              ram_we_s    = 1'b1;
              ram_wdata_s = data1;
              ready_s     = 1'b1;
              state_s     = RESP;
            end else begin
              cnt_s   = 3'd0;
              state_s = RD_WAIT;
            end
          end else if (addr1 >= IO_BASE) begin
            ready_s = 1'b1;
            state_s = RESP;
            if (w1 && (addr1 == IO_OUT_ADDR)) begin
              io_out_s = data1;
            end else if (!w1 && (addr1 == IO_IN_ADDR)) begin
              din_s = {2'b00, io_in};
            end else begin
              // Unmapped I/O register: flag it, no side effect beyond clearing read data.
              err_s = 1'b1;
              if (!w1) begin
                din_s = 18'd0;
              end else begin
                din_s = din_r;
              end
            end
          end else begin
            ready_s = 1'b1;
            err_s   = 1'b1;
            state_s = RESP;
            if (!w1) begin
              din_s = 18'd0;
            end else begin
              din_s = din_r;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r == LAST_CNT) begin
          din_s   = ram_rdata;
          ready_s = 1'b1;
          state_s = RESP;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign external_din = din_r;
  assign ready        = ready_r;
  assign err          = err_r;
  assign ram_addr     = ram_addr_r;
  assign ram_we       = ram_we_r;
  assign ram_wdata    = ram_wdata_r;
  assign io_out       = io_out_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: one instance with RAM_LATENCY=2
// for single transactions and resets, one with RAM_LATENCY=1 for back-to-back traffic.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        req, w1;
  logic [15:0] addr1, data1, io_in;

  logic [17:0] din_a, rdata_a, din_b, rdata_b;
  logic        ready_a, err_a, we_a, ready_b, err_b, we_b;
  logic [14:0] raddr_a, raddr_b;
  logic [15:0] wdata_a, ioout_a, wdata_b, ioout_b;

  logic [17:0] mem_a [0:255];
  logic [17:0] mem_b [0:255];

  int errors = 0;
  int checks = 0;
  int we_cnt_a = 0;

  always #5 clk = ~clk;

  mem_responder #(.RAM_LATENCY(2)) dut_a (
    .CLK(clk), .CLR(clr), .req(req), .w1(w1), .addr1(addr1), .data1(data1),
    .external_din(din_a), .ready(ready_a), .err(err_a), .ram_addr(raddr_a),
    .ram_we(we_a), .ram_wdata(wdata_a), .ram_rdata(rdata_a), .io_out(ioout_a),
    .io_in(io_in)
  );

  mem_responder #(.RAM_LATENCY(1)) dut_b (
    .CLK(clk), .CLR(clr), .req(req), .w1(w1), .addr1(addr1), .data1(data1),
    .external_din(din_b), .ready(ready_b), .err(err_b), .ram_addr(raddr_b),
    .ram_we(we_b), .ram_wdata(wdata_b), .ram_rdata(rdata_b), .io_out(ioout_b),
    .io_in(io_in)
  );

  // RAM models: written words are tagged with 2'b10 in the top bits.
  assign rdata_a = mem_a[raddr_a[7:0]];
  assign rdata_b = mem_b[raddr_b[7:0]];
  always @(posedge clk) begin
    if (we_a) mem_a[raddr_a[7:0]] <= {2'b10, wdata_a};
    if (we_b) mem_b[raddr_b[7:0]] <= {2'b10, wdata_b};
  end

  always @(negedge clk) if (we_a === 1'b1) we_cnt_a++;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] ioin;
    int          lat;
    logic        err;
    logic        we;
    logic [17:0] din;
    logic [15:0] io;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int we0;
    @(negedge clk);
    we0 = we_cnt_a;
    req = 1'b1; w1 = v.w; addr1 = v.addr; data1 = v.data; io_in = v.ioin;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge: the DUT must have latched them.
    req = 1'b0; w1 = ~v.w; addr1 = ~v.addr; data1 = ~v.data; io_in = ~v.ioin;
    @(negedge clk);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (ready_a === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_err", idx), err_a, v.err);
    chk($sformatf("v%0d_ram_we", idx), we_a, v.we);
    chk($sformatf("v%0d_din", idx), din_a, v.din);
    chk($sformatf("v%0d_io_out", idx), ioout_a, v.io);
    if (!v.addr[15]) chk($sformatf("v%0d_ram_addr", idx), raddr_a, v.addr[14:0]);
    if (v.we) chk($sformatf("v%0d_ram_wdata", idx), wdata_a, v.data);
    @(negedge clk);
    chk($sformatf("v%0d_pulses_low", idx), {ready_a, err_a, we_a}, 3'b000);
    chk($sformatf("v%0d_we_count", idx), we_cnt_a - we0, v.we ? 1 : 0);
  endtask

  initial begin
    int cnt;
    int acc [8];
    int pos;
    int i;
    logic        exp_rdy [24];
    logic        exp_we  [24];
    logic [17:0] exp_val [24];
    logic        exp_isw [24];

    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 18'd0;
      mem_b[k] = 18'd0;
    end
    // w, addr, data, io_in, latency, err, we, din, io_out
    vecs[0]  = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1, 1'b0, 1'b1, 18'h00000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0012, 16'h0000, 16'h0000, 3, 1'b0, 1'b0, 18'h2BEEF, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0034, 16'h1111, 16'h0000, 1, 1'b0, 1'b1, 18'h2BEEF, 16'h0000};
    vecs[3]  = '{1'b1, 16'hFF00, 16'h00A5, 16'h0000, 1, 1'b0, 1'b0, 18'h2BEEF, 16'h00A5};
    vecs[4]  = '{1'b0, 16'hFF01, 16'h0000, 16'h1234, 1, 1'b0, 1'b0, 18'h01234, 16'h00A5};
    vecs[5]  = '{1'b0, 16'h9000, 16'h0000, 16'h0000, 1, 1'b1, 1'b0, 18'h00000, 16'h00A5};
    vecs[6]  = '{1'b1, 16'hFF05, 16'h5555, 16'h0000, 1, 1'b1, 1'b0, 18'h00000, 16'h00A5};
    vecs[7]  = '{1'b1, 16'h7FFF, 16'h00C3, 16'h0000, 1, 1'b0, 1'b1, 18'h00000, 16'h00A5};
    vecs[8]  = '{1'b0, 16'h7FFF, 16'h0000, 16'h0000, 3, 1'b0, 1'b0, 18'h200C3, 16'h00A5};
    vecs[9]  = '{1'b0, 16'hFEFF, 16'h0000, 16'h0000, 1, 1'b1, 1'b0, 18'h00000, 16'h00A5};
    vecs[10] = '{1'b0, 16'h0034, 16'h0000, 16'h0000, 3, 1'b0, 1'b0, 18'h21111, 16'h00A5};
    vecs[11] = '{1'b1, 16'h8000, 16'h0F0F, 16'h0000, 1, 1'b1, 1'b0, 18'h21111, 16'h00A5};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1'b1, 1'b0, 18'h00000, 16'h00A5};
    vecs[13] = '{1'b1, 16'hFF00, 16'h003C, 16'h0000, 1, 1'b0, 1'b0, 18'h00000, 16'h003C};

    clr = 1'b0; req = 1'b0; w1 = 1'b0; addr1 = 16'd0; data1 = 16'd0; io_in = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {din_a, ready_a, err_a, raddr_a, we_a, wdata_a, ioout_a}, 32'd0);
    chk("reset_din", din_a, 18'd0);
    chk("reset_io_out", ioout_a, 16'd0);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_pulses", {ready_a, err_a, we_a, ready_b, err_b, we_b}, 6'd0);
    chk("idle_ram_addr", raddr_a, 15'd0);

    for (int v = 0; v < 14; v++) run_vec(vecs[v], v);

    // Reset one edge into a LAT=2 read: access aborts, no ready afterwards.
    @(negedge clk);
    req = 1'b1; w1 = 1'b0; addr1 = 16'h0012;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    #1;
    chk("rdabort_ready", ready_a, 1'b0);
    chk("rdabort_regs", {din_a, raddr_a}, 33'd0);
    chk("rdabort_io_out", ioout_a, 16'd0);
    @(negedge clk) clr = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready_a === 1'b1) cnt++;
    end
    chk("rdabort_no_ready", cnt, 0);

    // Reset while ram_we is high: it must drop at once.
    @(negedge clk);
    req = 1'b1; w1 = 1'b1; addr1 = 16'h0050; data1 = 16'h7777;
    @(posedge clk); #1 req = 1'b0;
    chk("wrabort_we_before", we_a, 1'b1);
    clr = 1'b0;
    #1;
    chk("wrabort_we_dropped", {we_a, ready_a}, 2'b00);
    @(negedge clk) clr = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready_a === 1'b1) cnt++;
    end
    chk("wrabort_no_ready", cnt, 0);
    run_vec('{1'b0, 16'h0012, 16'h0000, 16'h0000, 3, 1'b0, 1'b0, 18'h2BEEF, 16'h0000}, 99);

    // Back-to-back on LAT=1: req held high, alternating write/read.
    for (int k = 0; k < 24; k++) begin
      exp_rdy[k] = 1'b0; exp_we[k] = 1'b0; exp_val[k] = 18'd0; exp_isw[k] = 1'b0;
    end
    pos = 0;
    for (int r = 0; r < 8; r++) begin
      acc[r] = pos;
      if (r % 2 == 0) begin
        exp_rdy[pos] = 1'b1; exp_we[pos] = 1'b1; exp_isw[pos] = 1'b1;
        exp_val[pos] = {2'b00, 16'hA000 + 16'(r / 2)};
        pos += 2;
      end else begin
        exp_rdy[pos + 1] = 1'b1;
        exp_val[pos + 1] = {2'b10, 16'hA000 + 16'(r / 2)};
        pos += 3;
      end
    end
    repeat (3) @(negedge clk);
    i = 0;
    req = 1'b1; w1 = 1'b1; addr1 = 16'h0100; data1 = 16'hA000;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_c%0d_ready", k), ready_b, exp_rdy[k]);
      chk($sformatf("b2b_c%0d_we", k), we_b, exp_we[k]);
      if (exp_rdy[k]) begin
        chk($sformatf("b2b_c%0d_err", k), err_b, 1'b0);
        if (exp_isw[k]) chk($sformatf("b2b_c%0d_wdata", k), wdata_b, exp_val[k][15:0]);
        else chk($sformatf("b2b_c%0d_din", k), din_b, exp_val[k]);
      end
      if (i < 8 && k == acc[i]) begin
        i++;
        if (i < 8) begin
          w1 = (i % 2 == 0);
          addr1 = 16'h0100 + 16'(i / 2);
          data1 = (i % 2 == 0) ? 16'hA000 + 16'(i / 2) : 16'h0000;
        end else begin
          req = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
